frame_stream_tx: RTL and testbench
==================================

FRAME_STREAM_TX -- requirements
Module: frame_stream_tx

Interface
REQ-001 Parameters SHALL be: DATA_W, 8, pixel width; COLS, 4, pixels per row; ROWS, 4, rows per frame; ADDR_W, 8, buffer address width, at least clog2(COLS*ROWS).
REQ-002 Port clk_i  in  1  sole clock; all logic SHALL be rising-edge triggered.
REQ-003 Port rst_i  in  1  reset, synchronous and active-high.
REQ-004 Port start_i  in  1  frame-send request, sampled only in IDLE.
REQ-005 Port busy_o  out  1  high while a frame is in progress.
REQ-006 Port done_o  out  1  one-cycle pulse on frame completion.
REQ-007 Port mem_rd_o  out  1  pixel-buffer read strobe.
REQ-008 Port mem_addr_o  out  ADDR_W  pixel-buffer read address.
REQ-009 Port mem_data_i  in  DATA_W  read data, valid exactly 1 cycle after mem_rd_o.
REQ-010 Port src_data_o  out  DATA_W  Avalon-ST source data.
REQ-011 Port src_valid_o  out  1  Avalon-ST valid.
REQ-012 Port src_ready_i  in  1  Avalon-ST ready, readyLatency 0.
REQ-013 Port src_sop_o / src_eop_o  out  1 each  start/end of packet, qualified by src_valid_o.

Function
REQ-014 The FSM SHALL have states IDLE, READ, DRAIN, DONE: IDLE->READ on start_i; READ->DRAIN after the last read is issued; DRAIN->DONE when the EOP beat is accepted; DONE->IDLE unconditionally after one cycle.
REQ-015 Reads SHALL proceed in raster order, column inner and row outer, with mem_addr_o = row*COLS + col, wrapping col to 0 at COLS-1 and incrementing row.
REQ-016 Each frame SHALL issue exactly COLS*ROWS reads and emit exactly COLS*ROWS beats, in address order.
REQ-017 Returned data SHALL be captured into a 2-entry output FIFO; src_data_o/src_valid_o SHALL come from the FIFO head.
REQ-018 A read SHALL be issued only if occupancy + in-flight - pop < 2, where pop = src_valid_o & src_ready_i; FIFO overflow is never permitted.
REQ-019 A beat SHALL transfer only when src_valid_o & src_ready_i; while valid is high and ready is low, data, sop and eop SHALL hold stable.
REQ-020 src_sop_o SHALL be high only on beat 0; src_eop_o only on beat COLS*ROWS-1; COLS=ROWS=1 SHALL assert both on the single beat.
REQ-021 If start_i is sampled at edge T, mem_rd_o SHALL be high in cycle T+1 with address 0, and src_valid_o first in cycle T+3.
REQ-022 With src_ready_i held high, throughput SHALL be one beat per cycle with no bubbles after the first beat.
REQ-023 busy_o SHALL be high from cycle T+1 through the cycle in DONE; done_o SHALL be high only in the DONE cycle.
REQ-024 start_i outside IDLE SHALL be ignored; a start_i in the cycle after DONE SHALL begin a new frame.
REQ-025 src_ready_i may toggle arbitrarily, including high with src_valid_o low, with no effect.

Reset
REQ-026 rst_i SHALL override everything, including mid-frame: FSM to IDLE; counters, FIFO and in-flight flag cleared; busy_o, done_o, mem_rd_o, src_valid_o, src_sop_o, src_eop_o to 0; mem_addr_o and src_data_o to 0.
REQ-027 Read data returning in the cycle after reset SHALL be discarded.

Structure
REQ-028 FSM state encodings and default DATA_W SHALL reside in shared package frame_stream_pkg.
REQ-029 The column/row counter SHALL be sub-module raster_counter (inc, clear, col, row, last), instantiated once.

Verification (COLS=4, ROWS=2, memory[a]=8'hA0+a)
REQ-030 start pulse, ready held high -> beats A0..A7 on 8 consecutive cycles starting at T+3, sop on A0, eop on A7, done_o pulse one cycle after A7.
REQ-031 ready toggling 1,0,1,0 -> same 8 values in order, each held stable while ready is 0, no duplicates or drops.
REQ-032 ready low for 10 cycles from T+2 -> at most 2 reads outstanding or buffered, mem_rd_o low while full, stream resumes at A0.
REQ-033 rst_i asserted on the 4th accepted beat -> all outputs 0 next cycle; a new start then yields A0 with sop.
REQ-034 start_i held high continuously -> back-to-back frames separated by the DONE cycle, the second frame beginning A0 with sop.
REQ-035 COLS=ROWS=1 -> a single beat A0 with both sop and eop, then done_o.

Source files
------------

// File: rtl/frame_stream_pkg.sv
// frame_stream_pkg: shared FSM states and default pixel width for frame_stream_tx
package frame_stream_pkg;
  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;
  localparam int DATA_W_DEF = 8;
endpackage

// File: rtl/frame_stream_raster_counter.sv
// raster_counter: column-inner, row-outer raster position counter that wraps after the last pixel
module raster_counter #(
  parameter int COLS   = 4,
  parameter int ROWS   = 4,
  parameter int ADDR_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              inc,
  input  logic              clear,
  output logic [ADDR_W-1:0] col,
  output logic [ADDR_W-1:0] row,
  output logic              last
);
  logic col_end, row_end;
  assign col_end = col == ADDR_W'(COLS - 1);
  assign row_end = row == ADDR_W'(ROWS - 1);
  assign last = col_end && row_end;
  always_ff @(posedge clk_i)
    if (rst_i || clear) begin
      col <= '0;
      row <= '0;
    end else if (inc) begin
      col <= col_end ? '0 : col + 1'b1;
      row <= col_end ? (row_end ? '0 : row + 1'b1) : row;
    end
endmodule

// File: rtl/frame_stream_tx.sv
// frame_stream_tx: reads a COLS x ROWS frame from a pixel buffer and streams it out as one Avalon-ST packet
module frame_stream_tx
  import frame_stream_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int COLS   = 4,
  parameter int ROWS   = 4,
  parameter int ADDR_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              mem_rd_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic [DATA_W-1:0] mem_data_i,
  output logic [DATA_W-1:0] src_data_o,
  output logic              src_valid_o,
  input  logic              src_ready_i,
  output logic              src_sop_o,
  output logic              src_eop_o
);
  localparam logic [ADDR_W-1:0] LAST_BEAT = ADDR_W'(COLS * ROWS - 1);
  state_t state, state_n;
  logic [ADDR_W-1:0] col, row, beat;
  logic [DATA_W-1:0] d1;
  logic [1:0] cnt;
  logic [2:0] occ;
  logic last, in_flight, pop, room;
  raster_counter #(.COLS(COLS), .ROWS(ROWS), .ADDR_W(ADDR_W)) u_raster (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .inc(mem_rd_o),
    .clear(state == IDLE),
    .col(col),
    .row(row),
    .last(last)
  );
  assign pop = src_valid_o && src_ready_i;
  assign occ = {1'b0, cnt} + {2'b0, in_flight};
  assign room = occ < (pop ? 3'd3 : 3'd2);
  assign src_valid_o = cnt != 2'd0;
  assign src_sop_o = src_valid_o && beat == '0;
  assign src_eop_o = src_valid_o && beat == LAST_BEAT;
  assign mem_addr_o = ADDR_W'(row * COLS + col);
  assign busy_o = state != IDLE;
  assign done_o = state == DONE;
  always_comb begin
    mem_rd_o = 1'b0;
    state_n = state;
    mem_rd_o = state == READ && room;
    state_n = state == IDLE  ? (start_i ? READ : IDLE) :
              state == READ  ? (mem_rd_o && last ? DRAIN : READ) :
              state == DRAIN ? (pop && src_eop_o ? DONE : DRAIN) : IDLE;
  end
  always_ff @(posedge clk_i)
    if (rst_i) begin
      state <= IDLE;
      in_flight <= 1'b0;
      cnt <= '0;
      beat <= '0;
      src_data_o <= '0;
      d1 <= '0;
    end else begin
      state <= state_n;
      in_flight <= mem_rd_o;
      cnt <= cnt + {1'b0, in_flight} - {1'b0, pop};
      if (pop) beat <= src_eop_o ? '0 : beat + 1'b1;
      if (pop || (in_flight && cnt == 2'd0)) src_data_o <= pop && cnt == 2'd2 ? d1 : mem_data_i;
      if (in_flight && (pop ? cnt == 2'd2 : cnt == 2'd1)) d1 <= mem_data_i;
    end
endmodule

// File: tb/tb_frame_stream_tx.sv
// tb_frame_stream_tx: scoreboard bench for frame_stream_tx with 4x2 and 1x1 frames
module tb_frame_stream_tx;
  logic clk = 1'b0;
  logic rst, start, start1;
  bit rdy;
  int mode;
  logic busy, done, mem_rd, valid, sop, eop;
  logic [7:0] mem_addr, mem_data, data;
  logic busy1, done1, mem_rd1, valid1, sop1, eop1, rdy1;
  logic [7:0] mem_addr1, mem_data1, data1;
  int checks = 0, passed = 0;
  logic [9:0] exp_q[$];
  int rd_cnt = 0, acc_cnt = 0;
  bit held = 0;
  logic [10:0] held_v;
  assign rdy1 = 1'b1;
  always #5 clk = ~clk;
  frame_stream_tx #(.DATA_W(8), .COLS(4), .ROWS(2), .ADDR_W(8)) u0 (
    .clk_i(clk), .rst_i(rst), .start_i(start), .busy_o(busy), .done_o(done),
    .mem_rd_o(mem_rd), .mem_addr_o(mem_addr), .mem_data_i(mem_data),
    .src_data_o(data), .src_valid_o(valid), .src_ready_i(rdy),
    .src_sop_o(sop), .src_eop_o(eop)
  );
  frame_stream_tx #(.DATA_W(8), .COLS(1), .ROWS(1), .ADDR_W(8)) u1 (
    .clk_i(clk), .rst_i(rst), .start_i(start1), .busy_o(busy1), .done_o(done1),
    .mem_rd_o(mem_rd1), .mem_addr_o(mem_addr1), .mem_data_i(mem_data1),
    .src_data_o(data1), .src_valid_o(valid1), .src_ready_i(rdy1),
    .src_sop_o(sop1), .src_eop_o(eop1)
  );
  always @(posedge clk) begin
    mem_data <= 8'hA0 + mem_addr;
    mem_data1 <= 8'hA0 + mem_addr1;
  end
  always @(posedge clk) begin
    #1;
    rdy = mode == 1 ? ~rdy : mode != 2;
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else passed++;
  endtask
  always @(negedge clk) begin
    if (rst) begin
      rd_cnt = 0;
      acc_cnt = 0;
      held = 0;
    end else begin
      rd_cnt += int'(mem_rd);
      chk("outstanding<=2", (rd_cnt - acc_cnt - int'(valid && rdy)) <= 2, 1);
      if (held) chk("hold stable", {valid, sop, eop, data}, held_v);
      held = valid && !rdy;
      held_v = {valid, sop, eop, data};
      if (valid && rdy) begin
        if (exp_q.size() == 0) chk("unexpected beat", {data, sop, eop}, 0);
        else chk("beat", {data, sop, eop}, exp_q.pop_front());
        acc_cnt++;
      end
    end
  end
  task automatic push_frame();
    for (int i = 0; i < 8; i++) exp_q.push_back({8'hA0 + 8'(i), i == 0, i == 7});
  endtask
  task automatic start_pulse(input bit stall);
    @(posedge clk);
    #1 start = 1;
    @(posedge clk);
    #1 start = 0;
    @(negedge clk);
    chk("T+1 rd/addr/busy", {mem_rd, mem_addr, busy}, {1'b1, 8'h00, 1'b1});
    if (stall) mode = 2;
    @(negedge clk);
    chk("T+2 no valid", valid, 0);
    @(negedge clk);
    chk("T+3 valid", valid, 1);
  endtask
  task automatic wait_done();
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (done) break;
    end
    chk("done reached", done, 1);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  initial begin
    rst = 1;
    start = 0;
    start1 = 0;
    mode = 0;
    repeat (3) @(negedge clk);
    chk("reset ctrl", {busy, done, mem_rd, valid, sop, eop}, 0);
    chk("reset addr/data", {mem_addr, data}, 0);
    chk("reset small", {busy1, done1, mem_rd1, valid1, data1}, 0);
    @(posedge clk);
    #1 rst = 0;
    push_frame();
    start_pulse(0);
    for (int i = 0; i < 8; i++) begin
      if (i > 0) @(negedge clk);
      chk("burst beat", {valid, data}, {1'b1, 8'hA0 + 8'(i)});
    end
    @(negedge clk);
    chk("done after A7", done, 1);
    @(negedge clk);
    chk("idle after done", {busy, done}, 0);
    chk("burst drained", exp_q.size(), 0);
    mode = 1;
    push_frame();
    start_pulse(0);
    wait_done();
    mode = 0;
    chk("toggle drained", exp_q.size(), 0);
    push_frame();
    start_pulse(1);
    repeat (5) @(negedge clk);
    chk("stall held", {mem_rd, valid, sop, data}, {1'b0, 1'b1, 1'b1, 8'hA0});
    repeat (3) @(negedge clk);
    mode = 0;
    wait_done();
    chk("stall drained", exp_q.size(), 0);
    push_frame();
    start_pulse(0);
    repeat (3) @(negedge clk);
    chk("4th beat", {valid, data}, {1'b1, 8'hA3});
    #1 rst = 1;
    @(negedge clk);
    chk("mid reset outputs", {busy, done, mem_rd, valid, sop, eop, mem_addr, data}, 0);
    exp_q.delete();
    @(posedge clk);
    #1 rst = 0;
    push_frame();
    start_pulse(0);
    chk("restart sop/data", {sop, data}, {1'b1, 8'hA0});
    wait_done();
    chk("restart drained", exp_q.size(), 0);
    push_frame();
    push_frame();
    @(posedge clk);
    #1 start = 1;
    wait_done();
    @(negedge clk);
    chk("gap idle", {busy, done}, 0);
    @(negedge clk);
    chk("b2b restart", {mem_rd, mem_addr, busy}, {1'b1, 8'h00, 1'b1});
    start = 0;
    wait_done();
    chk("b2b drained", exp_q.size(), 0);
    @(posedge clk);
    #1 start1 = 1;
    @(posedge clk);
    #1 start1 = 0;
    @(negedge clk);
    chk("1x1 read", {mem_rd1, mem_addr1, busy1}, {1'b1, 8'h00, 1'b1});
    repeat (2) @(negedge clk);
    chk("1x1 beat", {valid1, sop1, eop1, data1}, {3'b111, 8'hA0});
    @(negedge clk);
    chk("1x1 done", {done1, valid1}, {1'b1, 1'b0});
    @(negedge clk);
    chk("1x1 idle", {busy1, done1}, 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
